// File: rtl/ghr_pkg.sv
// Shared types and defaults for the speculative global history register.
// Provides default HIST_W/NUM_CKPT plus history and checkpoint-id typedefs.
package ghr_pkg;

    localparam int GHR_HIST_W     = 32;
    localparam int GHR_NUM_CKPT   = 16;
    localparam int GHR_CKPT_IDX_W = $clog2(GHR_NUM_CKPT);

    typedef logic [GHR_HIST_W-1:0]     ghr_t;
    typedef logic [GHR_CKPT_IDX_W-1:0] ckpt_id_t;

endpackage

// File: rtl/ghr_ckpt_if.sv
// Frontend/backend bundle of the checkpointed GHR.
// master: shift/alloc/commit/recover/overwrite requests; slave: the GHR.
// GHR_RETIRED_HIST_EN adds retire_taken, flush_en and rdata_ret.
interface ghr_ckpt_if #(
    parameter int HIST_W   = ghr_pkg::GHR_HIST_W,
    parameter int NUM_CKPT = ghr_pkg::GHR_NUM_CKPT
);
    localparam int CKPT_IDX_W = $clog2(NUM_CKPT);

    logic                  shift_en;
    logic                  shift_data;
    logic                  ckpt_alloc;
    logic [CKPT_IDX_W-1:0] ckpt_id;
    logic                  ckpt_full;
    logic                  ckpt_empty;
    logic                  commit_en;
    logic                  recover_en;
    logic [CKPT_IDX_W-1:0] recover_id;
    logic                  recover_taken;
    logic                  wen;
    logic [HIST_W-1:0]     wdata;
    logic [HIST_W-1:0]     rdata;
    logic [HIST_W-1:0]     rdata_reg;
`ifdef GHR_RETIRED_HIST_EN
    logic                  retire_taken;
    logic                  flush_en;
    logic [HIST_W-1:0]     rdata_ret;

    modport master (
        output shift_en, shift_data, ckpt_alloc, commit_en,
        output recover_en, recover_id, recover_taken, wen, wdata,
        output retire_taken, flush_en,
        input  ckpt_id, ckpt_full, ckpt_empty, rdata, rdata_reg,
        input  rdata_ret
    );
    modport slave (
        input  shift_en, shift_data, ckpt_alloc, commit_en,
        input  recover_en, recover_id, recover_taken, wen, wdata,
        input  retire_taken, flush_en,
        output ckpt_id, ckpt_full, ckpt_empty, rdata, rdata_reg,
        output rdata_ret
    );
`else
    modport master (
        output shift_en, shift_data, ckpt_alloc, commit_en,
        output recover_en, recover_id, recover_taken, wen, wdata,
        input  ckpt_id, ckpt_full, ckpt_empty, rdata, rdata_reg
    );
    modport slave (
        input  shift_en, shift_data, ckpt_alloc, commit_en,
        input  recover_en, recover_id, recover_taken, wen, wdata,
        output ckpt_id, ckpt_full, ckpt_empty, rdata, rdata_reg
    );
`endif
endinterface

// File: rtl/ghr_ckpt_buf.sv
// Circular checkpoint buffer: snapshot RAM plus head/tail/count and full/empty.
// Ports: alloc/commit/recover/flush requests in; tail id, status, snapshot out.
module ghr_ckpt_buf import ghr_pkg::*; #(
    parameter  int HIST_W   = GHR_HIST_W,
    parameter  int NUM_CKPT = GHR_NUM_CKPT,
    localparam int IW       = $clog2(NUM_CKPT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              alloc_i,
    input  logic [HIST_W-2:0] alloc_data_i,
    input  logic              commit_i,
    input  logic              recover_i,
    input  logic [IW-1:0]     recover_id_i,
    output logic [HIST_W-2:0] rd_data_o,
    output logic [IW-1:0]     tail_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              commit_ok_o
);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(NUM_CKPT);

    // The snapshot MSB is shifted out on restore, so it is never stored.
    logic [HIST_W-2:0] mem_q [NUM_CKPT];
    logic [IW-1:0]     head_q, head_d, tail_q, tail_d, head_nx, span;
    logic [IW:0]       count_q, count_d;
    logic              alloc_ok, commit_ok, self_free;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign tail_o      = tail_q;
    assign rd_data_o   = mem_q[recover_id_i];
    assign commit_ok_o = commit_ok;

    always_comb begin
        alloc_ok  = alloc_i & ~full_o;
        commit_ok = commit_i & ~empty_o;
        head_nx   = head_q + IW'(commit_ok);
        span      = recover_id_i + IW'(1) - head_nx;
        // Committing the recovered entry itself leaves nothing live.
        self_free = commit_ok & (head_q == recover_id_i);
        head_d    = head_nx;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (recover_i) begin
            tail_d = recover_id_i + IW'(1);
            // Zero span with a live entry means every slot is in use.
            if (span == '0 && !self_free) count_d = FULL_CNT;
            else                          count_d = {1'b0, span};
        end else begin
            if (alloc_ok) tail_d = tail_q + IW'(1);
            count_d = count_q + (IW+1)'(alloc_ok) - (IW+1)'(commit_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && alloc_ok) mem_q[tail_q] <= alloc_data_i;
    end

    a_alloc_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(alloc_i && full_o));

    a_rec_live: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        recover_i |-> ({1'b0, IW'(recover_id_i - head_q)} < count_q));

endmodule

// File: rtl/ghr_ckpt.sv
// Speculative global history register with circular checkpoint buffer.
// Ports: clk, rst, bus (ghr_ckpt_if.slave); macro GHR_RETIRED_HIST_EN.
module ghr_ckpt import ghr_pkg::*; #(
    parameter  int HIST_W     = GHR_HIST_W,
    parameter  int NUM_CKPT   = GHR_NUM_CKPT,
    localparam int CKPT_IDX_W = $clog2(NUM_CKPT)
) (
    input logic       clk,
    input logic       rst,
    ghr_ckpt_if.slave bus
);
    logic [HIST_W-1:0] hist_q, hist_d, flush_hist;
    logic [HIST_W-2:0] snap;
    logic              flush, alloc_req, shift_ok, full, commit_ok;

`ifdef GHR_RETIRED_HIST_EN
    logic [HIST_W-1:0] ret_q, ret_d;

    assign flush         = bus.flush_en;
    assign ret_d         = commit_ok ? {ret_q[HIST_W-2:0], bus.retire_taken}
                                     : ret_q;
    assign flush_hist    = ret_d;
    assign bus.rdata_ret = ret_q;

    always_ff @(posedge clk) begin
        if (rst) ret_q <= '0;
        else     ret_q <= ret_d;
    end
`else
    assign flush      = 1'b0;
    assign flush_hist = '0;
`endif

    assign alloc_req = bus.shift_en & bus.ckpt_alloc & ~bus.recover_en
                     & ~bus.wen & ~flush;
    // An alloc that cannot get an entry drops its shift as well.
    assign shift_ok  = bus.shift_en & ~(bus.ckpt_alloc & full);

    ghr_ckpt_buf #(
        .HIST_W   (HIST_W),
        .NUM_CKPT (NUM_CKPT)
    ) u_buf (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .alloc_i      (alloc_req),
        .alloc_data_i (hist_q[HIST_W-2:0]),
        .commit_i     (bus.commit_en),
        .recover_i    (bus.recover_en),
        .recover_id_i (bus.recover_id),
        .rd_data_o    (snap),
        .tail_o       (bus.ckpt_id),
        .full_o       (full),
        .empty_o      (bus.ckpt_empty),
        .commit_ok_o  (commit_ok)
    );

    always_comb begin
        hist_d = hist_q;
        if (rst)                 hist_d = '0;
        else if (flush)          hist_d = flush_hist;
        else if (bus.recover_en) hist_d = {snap, bus.recover_taken};
        else if (bus.wen)        hist_d = bus.wdata;
        else if (shift_ok)       hist_d = {hist_q[HIST_W-2:0], bus.shift_data};
    end

    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else     hist_q <= hist_d;
    end

    assign bus.ckpt_full = full;
    assign bus.rdata     = hist_d;
    assign bus.rdata_reg = hist_q;

endmodule
